// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - shared widths, op codes, FSM states and sign helpers for the MDU
package mdu_ctrl_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  // funct3 encodings of the M-extension ops
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  // Sequencer states
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM
  function automatic logic a_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV and REM
  function automatic logic b_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - EX-stage request/result bundle between pipeline and MDU
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, a, b, flush, input busy, stall, done, result);
  modport slave  (input start, op, a, b, flush, output busy, stall, done, result);

endinterface

// File: rtl/mdu_ctrl_step.sv
// rtl/mdu_ctrl_step.sv - one combinational shift-add or restoring-divide iteration
module mdu_step
  import mdu_ctrl_pkg::*;
(
  input  step_mode_e        i_mode,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  output logic [2*XLEN-1:0] o_acc,
  output logic              o_qbit
);

  // Multiply: acc = {partial product high, remaining multiplier bits}
  logic [XLEN:0]   w_sum;
  // Divide: acc = {remainder, dividend bits shifting out / quotient bits shifting in}
  logic [2*XLEN:0] w_sh;
  logic [XLEN+1:0] w_diff;
  logic            w_unused_bit;

  assign w_sum        = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_opnd & {XLEN{i_acc[0]}}};
  assign w_sh         = {i_acc, 1'b0};
  assign w_diff       = {1'b0, w_sh[2*XLEN:XLEN]} - {2'b00, i_opnd};
  // A successful subtract always leaves a remainder below the divisor, so bit XLEN is zero
  assign w_unused_bit = w_diff[XLEN];

  // Select the iteration; the quotient bit is merged into acc[0] by the caller
  always_comb begin
    o_acc  = '0;
    o_qbit = 1'b0;
    if (i_mode == STEP_MUL) begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end else begin
      o_qbit = ~w_diff[XLEN+1];
      o_acc  = o_qbit ? {w_diff[XLEN-1:0], w_sh[XLEN-1:0]} : w_sh[2*XLEN-1:0];
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - iterative RV32M multiply/divide sequencer (optional MDU_EARLY_OUT_EN)
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  mdu_ctrl_if.slave bus
);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic              r_sa;
  logic              r_sb;
  logic              r_byp;
  logic [XLEN-1:0]   r_byp_val;
  logic [XLEN-1:0]   r_opnd;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;
  logic              r_done;

  logic              w_idle;
  logic              w_busy;
  logic              w_accept;
  logic              w_is_div;
  logic              w_is_rem;
  logic              w_sa;
  logic              w_sb;
  logic              w_div0;
  logic              w_early;
  logic              w_qbit;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN-1:0]   w_early_val;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_step_acc;
  step_mode_e        w_mode;

  // DONE behaves like IDLE for accepting the next op
  assign w_idle   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_busy   = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
  assign w_accept = bus.start & ~bus.flush & w_idle;
  assign w_is_div = bus.op[2];
  assign w_is_rem = bus.op[2] & bus.op[1];
  assign w_sa     = bus.a[XLEN-1] & a_signed(bus.op);
  assign w_sb     = bus.b[XLEN-1] & b_signed(bus.op);
  assign w_mag_a  = magnitude(bus.a, w_sa);
  assign w_mag_b  = magnitude(bus.b, w_sb);
  assign w_div0   = w_is_div && (bus.b == '0);
  assign w_mode   = (r_state == S_DIV) ? STEP_DIV : STEP_MUL;

`ifdef MDU_EARLY_OUT_EN
  // Trivially-known results skip the iterations entirely
  assign w_early     = (!w_is_div && ((bus.a == '0) || (bus.b == '0))) ||
                       (((bus.op == OP_DIVU) || (bus.op == OP_REMU)) && (bus.a < bus.b));
  assign w_early_val = (bus.op == OP_REMU) ? bus.a : '0;
`else
  assign w_early     = 1'b0;
  assign w_early_val = '0;
`endif

  assign bus.busy   = w_busy;
  assign bus.stall  = (bus.start & w_idle) | w_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

  mdu_step u_step (
    .i_mode (w_mode),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_step_acc),
    .o_qbit (w_qbit)
  );

  // Sign correction and word selection applied in FIX
  always_comb begin
    w_prod = (r_sa ^ r_sb) ? (~r_acc + 1'b1) : r_acc;
    w_quot = (r_sa ^ r_sb) ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
    w_rem  = r_sa ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
    w_fix  = '0;
    if (r_byp) begin
      w_fix = r_byp_val;
    end else begin
      case (r_op)
        OP_MUL:                       w_fix = w_prod[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: w_fix = w_prod[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:              w_fix = w_quot;
        default:                      w_fix = w_rem;
      endcase
    end
  end

  // Sequencer: accept, iterate 32 times, correct sign, then pulse done
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_byp     <= 1'b0;
      r_byp_val <= '0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.flush && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            r_state <= S_IDLE;
            if (w_accept) begin
              r_op      <= bus.op;
              r_sa      <= w_sa;
              r_sb      <= w_sb;
              r_cnt     <= '0;
              r_byp     <= w_div0 | w_early;
              r_byp_val <= w_div0 ? (w_is_rem ? bus.a : '1) : w_early_val;
              r_opnd    <= w_is_div ? w_mag_b : w_mag_a;
              r_acc     <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
              if (w_div0 || w_early) begin
                r_state <= S_FIX;
              end else if (w_is_div) begin
                r_state <= S_DIV;
              end else begin
                r_state <= S_MUL;
              end
            end
          end
          S_MUL, S_DIV: begin
            r_acc <= w_step_acc | {{(2*XLEN-1){1'b0}}, w_qbit};
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(XLEN-1)) begin
              r_state <= S_FIX;
            end
          end
          S_FIX: begin
            r_result <= w_fix;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
